acc_result_drain: RTL and testbench

- Consumer for the convolution accumulator. When the final tap of an output sample has been accumulated, this block captures the 21-bit sum and scales it by an arithmetic right shift. It then saturates the result to 16-bit signed.
- Results are buffered in a small FIFO and presented downstream on a valid/ready interface.
- Drives the accumulator's clear_acc on every accepted capture. Asserts stall upstream when the buffer is full.

---
 rtl/acc_result_drain_if.sv | 24 ++
 rtl/acc_result_drain.sv | 120 ++++++++++++
 tb/tb_acc_result_drain.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/acc_result_drain_if.sv
// Bundle of the accumulator capture handshake and the downstream valid/ready result bus.
interface acc_result_drain_if #(
  parameter int ACC_W = 21,
  parameter int OUT_W = 16
);
  logic [ACC_W-1:0] acc_data_i;
  logic             acc_done_i;
  logic             clear_acc_o;
  logic             stall_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] out_data_o;
  logic             out_sat_o;

  modport master (
    input  acc_data_i, acc_done_i, out_ready_i,
    output clear_acc_o, stall_o, out_valid_o, out_data_o, out_sat_o
  );

  modport slave (
    output acc_data_i, acc_done_i, out_ready_i,
    input  clear_acc_o, stall_o, out_valid_o, out_data_o, out_sat_o
  );
endinterface

// File: rtl/acc_result_drain.sv
// Scales/saturates completed accumulator sums into a DEPTH-entry FIFO; push->valid is one cycle, stall_o when full.
// DRAIN_ROUND_EN selects round-half-up scaling; the default build truncates.
module acc_result_drain #(
  parameter int ACC_W = 21,
  parameter int OUT_W = 16,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  acc_result_drain_if.master bus,
  output logic               ovf_o,
  output logic [7:0]         result_cnt_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW = ACC_W + 1;
  localparam logic signed [XW-1:0] SAT_HI = XW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;
  localparam logic [PW:0]          FULL_CNT = (PW + 1)'(DEPTH);
`ifdef DRAIN_ROUND_EN
  localparam logic signed [XW-1:0] RND = XW'(1 << (SHIFT - 1));
`else
  localparam logic signed [XW-1:0] RND = '0;
`endif

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] dat;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            res_cnt_q, res_cnt_d;

  logic signed [XW-1:0]  sum_x;
  logic signed [XW-1:0]  scl_x;
  entry_t                entry_d;
  entry_t                head;
  logic                  full, empty, push, pop;

  always_comb begin
    sum_x       = $signed({bus.acc_data_i[ACC_W-1], bus.acc_data_i}) + RND;
    scl_x       = sum_x >>> SHIFT;
    entry_d.sat = 1'b0;
    entry_d.dat = scl_x[OUT_W-1:0];
    if (scl_x > SAT_HI) begin
      entry_d.sat = 1'b1;
      entry_d.dat = SAT_HI[OUT_W-1:0];
    end else if (scl_x < SAT_LO) begin
      entry_d.sat = 1'b1;
      entry_d.dat = SAT_LO[OUT_W-1:0];
    end
  end

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = bus.acc_done_i & ~full;
  assign pop   = ~empty & bus.out_ready_i;
  assign head  = mem_q[rd_ptr_q];

  assign bus.clear_acc_o = push;
  assign bus.stall_o     = full;
  assign bus.out_valid_o = ~empty;
  assign bus.out_data_o  = empty ? '0 : head.dat;
  assign bus.out_sat_o   = empty ? 1'b0 : head.sat;
  assign ovf_o           = ovf_q;
  assign result_cnt_o    = res_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_cnt_d = res_cnt_q;
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PW'(1);
      res_cnt_d = res_cnt_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (bus.acc_done_i && full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

endmodule

// File: tb/tb_acc_result_drain.sv
// Directed bench for acc_result_drain: rounding, saturation, full/overflow, concurrent push/pop, async reset.
module tb_acc_result_drain;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ovf;
  logic [7:0] rcnt;
  int         n_chk = 0;
  int         n_err = 0;

`ifdef DRAIN_ROUND_EN
  localparam logic [15:0] EXP_POS = 16'h0013;
  localparam logic [15:0] EXP_NEG = 16'hFFFF;
`else
  localparam logic [15:0] EXP_POS = 16'h0012;
  localparam logic [15:0] EXP_NEG = 16'hFFFE;
`endif

  acc_result_drain_if #(.ACC_W(21), .OUT_W(16)) bus ();

  acc_result_drain #(.ACC_W(21), .OUT_W(16), .SHIFT(4), .DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .ovf_o        (ovf),
    .result_cnt_o (rcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [20:0] v, input logic exp_clr, input string tag);
    bus.acc_data_i = v;
    bus.acc_done_i = 1'b1;
    #1;
    check(tag, 32'(bus.clear_acc_o), 32'(exp_clr));
    tick();
    bus.acc_done_i = 1'b0;
  endtask

  task automatic head(input string tag, input logic [15:0] dat, input logic sat);
    check({tag, "_vld"}, 32'(bus.out_valid_o), 32'd1);
    check({tag, "_dat"}, 32'(bus.out_data_o), 32'(dat));
    check({tag, "_sat"}, 32'(bus.out_sat_o), 32'(sat));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: sim still running at 50000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.acc_data_i  = '0;
    bus.acc_done_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    #3;
    check("rst_vld", 32'(bus.out_valid_o), 32'd0);
    check("rst_stall", 32'(bus.stall_o), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_cnt", 32'(rcnt), 32'd0);
    check("rst_dat", 32'(bus.out_data_o), 32'd0);
    check("rst_sat", 32'(bus.out_sat_o), 32'd0);
    #9 reset_n = 1'b1;
    tick();

    // rounding, positive and negative
    bus.out_ready_i = 1'b1;
    push_one(21'h000128, 1'b1, "clr_pos");
    head("pos", EXP_POS, 1'b0);
    check("cnt_pos", 32'(rcnt), 32'd1);
    tick();
    check("pos_drained", 32'(bus.out_valid_o), 32'd0);
    push_one(21'h1FFFE8, 1'b1, "clr_neg");
    head("neg", EXP_NEG, 1'b0);
    tick();
    check("neg_drained", 32'(bus.out_valid_o), 32'd0);

    // saturation, held then drained in order
    bus.out_ready_i = 1'b0;
    push_one(21'h0FFFFF, 1'b1, "clr_sat_hi");
    push_one(21'h100000, 1'b1, "clr_sat_lo");
    head("sat_hi", 16'h7FFF, 1'b1);
    bus.out_ready_i = 1'b1;
    tick();
    head("sat_lo", 16'h8000, 1'b1);
    tick();
    check("sat_drained", 32'(bus.out_valid_o), 32'd0);
    check("sat_dat_empty", 32'(bus.out_data_o), 32'd0);
    check("cnt_sat", 32'(rcnt), 32'd4);
    bus.out_ready_i = 1'b0;

    // fill to full, overflow, full-with-pop rejection, drain
    for (int i = 1; i <= 4; i++) push_one(21'(i * 16), 1'b1, "clr_fill");
    check("stall_full", 32'(bus.stall_o), 32'd1);
    check("cnt_full", 32'(rcnt), 32'd8);
    push_one(21'h000050, 1'b0, "clr_ovf");
    check("ovf_set", 32'(ovf), 32'd1);
    check("cnt_ovf", 32'(rcnt), 32'd8);
    bus.out_ready_i = 1'b1;
    bus.acc_data_i  = 21'h000060;
    bus.acc_done_i  = 1'b1;
    #1;
    check("clr_full_pop", 32'(bus.clear_acc_o), 32'd0);
    head("drain1", 16'h0001, 1'b0);
    tick();
    bus.acc_done_i = 1'b0;
    check("stall_drop", 32'(bus.stall_o), 32'd0);
    check("cnt_full_pop", 32'(rcnt), 32'd8);
    head("drain2", 16'h0002, 1'b0);
    tick();
    head("drain3", 16'h0003, 1'b0);
    tick();
    head("drain4", 16'h0004, 1'b0);
    tick();
    check("drain_empty", 32'(bus.out_valid_o), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);
    bus.out_ready_i = 1'b0;

    // concurrent push and pop with two entries held
    push_one(21'h000050, 1'b1, "clr_pp5");
    push_one(21'h000060, 1'b1, "clr_pp6");
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.acc_data_i = 21'((7 + i) * 16);
      bus.acc_done_i = 1'b1;
      #1;
      check("clr_pp", 32'(bus.clear_acc_o), 32'd1);
      tick();
      head("pp_head", 16'(6 + i), 1'b0);
      check("pp_stall", 32'(bus.stall_o), 32'd0);
    end
    bus.acc_done_i = 1'b0;
    tick();
    head("pp_tail", 16'h0009, 1'b0);
    tick();
    check("pp_empty", 32'(bus.out_valid_o), 32'd0);
    check("cnt_pp", 32'(rcnt), 32'd13);
    bus.out_ready_i = 1'b0;

    // asynchronous reset between edges with 3 entries held
    for (int i = 1; i <= 3; i++) push_one(21'(i * 16), 1'b1, "clr_pre_rst");
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    check("pre_rst_cnt", 32'(rcnt), 32'd16);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_vld", 32'(bus.out_valid_o), 32'd0);
    check("mid_rst_stall", 32'(bus.stall_o), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_cnt", 32'(rcnt), 32'd0);
    check("mid_rst_dat", 32'(bus.out_data_o), 32'd0);
    #1 reset_n = 1'b1;
    tick();
    push_one(21'h000070, 1'b1, "clr_post_rst");
    head("post_rst", 16'h0007, 1'b0);
    check("cnt_post_rst", 32'(rcnt), 32'd1);
    bus.out_ready_i = 1'b1;
    tick();
    check("post_rst_empty", 32'(bus.out_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
